// File: rtl/alu_cmd_frontend.sv
// Byte-stream command front end for a 32-bit ALU: collects opcode/operand frames,
// issues one command at a time and returns the result as a little-endian byte stream.
`timescale 1ns/1ps
module alu_cmd_frontend #(
   parameter int unsigned timeout_p = 1000000
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        alu_valid_o,
   output logic [1:0]  alu_opcode_o,
   output logic [31:0] alu_operand_a_o,
   output logic [31:0] alu_operand_b_o,
   input  logic        alu_ready_i,
   input  logic        alu_valid_i,
   input  logic [63:0] alu_result_i,
   output logic        alu_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        frame_drop_o
);

   typedef enum logic [2:0] {
      GET_OP      = 3'd0,
      GET_A       = 3'd1,
      GET_B       = 3'd2,
      ISSUE       = 3'd3,
      WAIT_RESULT = 3'd4,
      SEND        = 3'd5
   } state_t;

   localparam logic [31:0] tmo_last_c = (timeout_p == 32'd0) ? 32'd0 : timeout_p - 32'd1;

   state_t      state_r;
   state_t      state_s;
   logic [2:0]  idx_r;
   logic [1:0]  opcode_r;
   logic [31:0] operand_a_r;
   logic [31:0] operand_b_r;
   logic [63:0] result_r;
   logic [31:0] tmo_cnt_r;
   logic        frame_drop_r;
   logic        ready_en_r;

   logic        rx_fire_s;
   logic        alu_issue_s;
   logic        alu_capture_s;
   logic        tx_fire_s;
   logic        in_get_s;
   logic        timeout_s;
   logic        advance_s;
   logic [2:0]  last_tx_idx_s;
   logic        unused_s;

   // rx_ready stays low until the first clock after reset release
   assign rx_ready_o    = ready_en_r &&
                          ((state_r == GET_OP) || (state_r == GET_A) || (state_r == GET_B));
   assign alu_valid_o   = (state_r == ISSUE);
   assign alu_ready_o   = (state_r == WAIT_RESULT);
   assign tx_valid_o    = (state_r == SEND);
   assign busy_o        = (state_r != GET_OP);
   assign frame_drop_o  = frame_drop_r;
   assign alu_opcode_o  = opcode_r;
   assign alu_operand_a_o = operand_a_r;
   assign alu_operand_b_o = operand_b_r;
   assign tx_data_o     = (state_r == SEND) ? result_r[{idx_r, 3'b000} +: 8] : 8'h00;

   assign rx_fire_s     = rx_valid_i && rx_ready_o;
   assign alu_issue_s   = alu_valid_o && alu_ready_i;
   assign alu_capture_s = alu_valid_i && alu_ready_o;
   assign tx_fire_s     = tx_valid_o && tx_ready_i;
   assign in_get_s      = (state_r == GET_A) || (state_r == GET_B);
   // An accepted byte always beats an expiring counter
   assign timeout_s     = (timeout_p != 32'd0) && in_get_s && !rx_fire_s &&
                          (tmo_cnt_r == tmo_last_c);
   assign advance_s     = (in_get_s && rx_fire_s) || tx_fire_s;
   assign last_tx_idx_s = (opcode_r == 2'd3) ? 3'd7 : 3'd3;
   assign unused_s      = &{1'b0, rx_data_i[7:2]};

   // State register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r <= GET_OP;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         GET_OP: begin
            if (rx_fire_s && (rx_data_i[1:0] != 2'd0)) state_s = GET_A;
            else                                       state_s = GET_OP;
         end
         GET_A: begin
            if (timeout_s)                          state_s = GET_OP;
            else if (rx_fire_s && (idx_r == 3'd3))  state_s = GET_B;
            else                                    state_s = GET_A;
         end
         GET_B: begin
            if (timeout_s)                          state_s = GET_OP;
            else if (rx_fire_s && (idx_r == 3'd3))  state_s = ISSUE;
            else                                    state_s = GET_B;
         end
         ISSUE: begin
            if (alu_issue_s) state_s = WAIT_RESULT;
            else             state_s = ISSUE;
         end
         WAIT_RESULT: begin
            if (alu_capture_s) state_s = SEND;
            else               state_s = WAIT_RESULT;
         end
         SEND: begin
            if (tx_fire_s && (idx_r == last_tx_idx_s)) state_s = GET_OP;
            else                                       state_s = SEND;
         end
         default: state_s = GET_OP;
      endcase
   end

   // Byte index, operand/result capture, timeout counter and drop pulse
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         idx_r        <= 3'd0;
         opcode_r     <= 2'd0;
         operand_a_r  <= 32'd0;
         operand_b_r  <= 32'd0;
         result_r     <= 64'd0;
         tmo_cnt_r    <= 32'd0;
         frame_drop_r <= 1'b0;
         ready_en_r   <= 1'b0;
      end else begin
         ready_en_r   <= 1'b1;
         frame_drop_r <= timeout_s;

         if (state_s != state_r) idx_r <= 3'd0;
         else if (advance_s)     idx_r <= idx_r + 3'd1;
         else                    idx_r <= idx_r;

         if ((state_r == GET_OP) && rx_fire_s && (rx_data_i[1:0] != 2'd0)) begin
            opcode_r <= rx_data_i[1:0];
         end

         if (timeout_s) begin
            operand_a_r <= 32'd0;
            operand_b_r <= 32'd0;
         end else if (rx_fire_s && (state_r == GET_A)) begin
            operand_a_r[{idx_r[1:0], 3'b000} +: 8] <= rx_data_i;
         end else if (rx_fire_s && (state_r == GET_B)) begin
            operand_b_r[{idx_r[1:0], 3'b000} +: 8] <= rx_data_i;
         end

         if (!in_get_s || rx_fire_s || timeout_s || (timeout_p == 32'd0)) tmo_cnt_r <= 32'd0;
         else                                                            tmo_cnt_r <= tmo_cnt_r + 32'd1;

         if (alu_capture_s) result_r <= alu_result_i;
      end
   end

endmodule
